// File: rtl/fu_complete_buffer.sv
// rtl/fu_complete_buffer.sv - per-FU completion FIFOs with round-robin arbitration onto the CDB
package fu_complete_pkg;
    typedef struct packed {
        logic        valid;
        logic        halt;
        logic [5:0]  dest_pr;
        logic [31:0] dest_value;
        logic [4:0]  rob_entry;
    } fu_complete_packet_t;
endpackage

module fu_complete_buffer
    import fu_complete_pkg::*;
#(
    parameter int NUM_FU       = 4,
    parameter int CDB_WIDTH    = 2,
    parameter int QDEPTH       = 8,
    parameter int STALL_MARGIN = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    input  logic [NUM_FU-1:0]     want_to_complete,
    input  fu_complete_packet_t   fu_packet_in [NUM_FU],
    output logic [NUM_FU-1:0]     complete_stall,
    output logic [CDB_WIDTH-1:0]  cdb_valid,
    output fu_complete_packet_t   cdb_packet_out [CDB_WIDTH],
    output logic                  overflow_err
);
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;
    localparam int GW = $clog2(CDB_WIDTH + 1);
    localparam logic [CW-1:0] FULL_LVL  = CW'(QDEPTH);
    localparam logic [CW-1:0] STALL_LVL = CW'(QDEPTH - STALL_MARGIN);

    fu_complete_packet_t mem [NUM_FU][QDEPTH];
    logic [AW-1:0]       rd_ptr [NUM_FU];
    logic [AW-1:0]       wr_ptr [NUM_FU];
    logic [CW-1:0]       count  [NUM_FU];
    logic [PW-1:0]       rr_ptr;

    logic [NUM_FU-1:0]    grant;
    logic [NUM_FU-1:0]    enq;
    logic [NUM_FU-1:0]    enq_ok;
    logic [CDB_WIDTH-1:0] slot_valid;
    fu_complete_packet_t  slot_pkt [CDB_WIDTH];
    logic [PW-1:0]        rr_next;

    function automatic logic [PW-1:0] fu_wrap(input logic [PW:0] v);
        if (v >= (PW+1)'(NUM_FU)) begin
            return PW'(v - (PW+1)'(NUM_FU));
        end
        return v[PW-1:0];
    endfunction

    // Scan from rr_ptr; the k-th non-empty FIFO found fills slot k.
    always_comb begin : grant_scan
        logic [GW-1:0] ngrant;
        logic [PW-1:0] idx;
        grant      = '0;
        slot_valid = '0;
        rr_next    = rr_ptr;
        ngrant     = '0;
        idx        = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            slot_pkt[k] = '0;
        end
        for (int j = 0; j < NUM_FU; j++) begin
            idx = fu_wrap({1'b0, rr_ptr} + (PW+1)'(j));
            if (count[idx] != '0 && ngrant < GW'(CDB_WIDTH)) begin
                grant[idx]                = 1'b1;
                slot_valid[ngrant[SW-1:0]] = 1'b1;
                slot_pkt[ngrant[SW-1:0]]   = mem[idx][rd_ptr[idx]];
                ngrant                    = ngrant + 1'b1;
                rr_next                   = fu_wrap({1'b0, idx} + (PW+1)'(1));
            end
        end
    end

    // A full FIFO still accepts when its head leaves in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            enq[i]            = want_to_complete[i] && fu_packet_in[i].valid;
            enq_ok[i]         = enq[i] && (count[i] != FULL_LVL || grant[i]);
            complete_stall[i] = (count[i] >= STALL_LVL);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (reset && !squash && enq_ok[i]) begin
                mem[i][wr_ptr[i]] <= fu_packet_in[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || squash) begin
            for (int i = 0; i < NUM_FU; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            rr_ptr    <= '0;
            cdb_valid <= '0;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_packet_out[k] <= '0;
            end
            if (!reset) begin
                overflow_err <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (enq_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (grant[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                count[i] <= count[i] + CW'(enq_ok[i]) - CW'(grant[i]);
                if (enq[i] && !enq_ok[i]) begin
                    overflow_err <= 1'b1;
                end
            end
            rr_ptr    <= rr_next;
            cdb_valid <= slot_valid;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_packet_out[k] <= slot_pkt[k];
            end
        end
    end
endmodule

// File: tb/tb_fu_complete_buffer.sv
// tb/tb_fu_complete_buffer.sv - table vectors, corner sequences and random stimulus against a queue model
module tb_fu_complete_buffer;
    import fu_complete_pkg::*;

    localparam int NUM_FU       = 4;
    localparam int CDB_WIDTH    = 2;
    localparam int QDEPTH       = 8;
    localparam int STALL_MARGIN = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 squash = 1'b0;
    logic [NUM_FU-1:0]    want = '0;
    fu_complete_packet_t  fu_in [NUM_FU];
    logic [NUM_FU-1:0]    complete_stall;
    logic [CDB_WIDTH-1:0] cdb_valid;
    fu_complete_packet_t  cdb_packet_out [CDB_WIDTH];
    logic                 overflow_err;

    always #5 clock = ~clock;

    fu_complete_buffer #(
        .NUM_FU(NUM_FU), .CDB_WIDTH(CDB_WIDTH), .QDEPTH(QDEPTH), .STALL_MARGIN(STALL_MARGIN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .squash(squash),
        .want_to_complete(want),
        .fu_packet_in(fu_in),
        .complete_stall(complete_stall),
        .cdb_valid(cdb_valid),
        .cdb_packet_out(cdb_packet_out),
        .overflow_err(overflow_err)
    );

    // Reference: one queue per FU, broadcast order picked by a rotating scan.
    fu_complete_packet_t  mq [NUM_FU][$];
    int                   m_rr;
    logic                 m_ovf;
    logic [CDB_WIDTH-1:0] m_valid;
    fu_complete_packet_t  m_out [CDB_WIDTH];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst_n;
        logic       sq;
        logic [3:0] want;
        logic [1:0] ev;
        logic [3:0] es;
        logic       eo;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [63:0] pk64(input fu_complete_packet_t p);
        logic [63:0] v;
        v = '0;
        v[$bits(fu_complete_packet_t)-1:0] = p;
        return v;
    endfunction

    function automatic fu_complete_packet_t rand_pkt();
        fu_complete_packet_t p;
        p.valid      = 1'b1;
        p.halt       = ($urandom_range(0, 15) == 0);
        p.dest_pr    = 6'($urandom);
        p.dest_value = $urandom;
        p.rob_entry  = 5'($urandom);
        return p;
    endfunction

    task automatic check_bits(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        int k;
        int last;
        k    = 0;
        last = 0;
        if (!reset || squash) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            m_rr    = 0;
            m_valid = '0;
            for (int s = 0; s < CDB_WIDTH; s++) m_out[s] = '0;
            if (!reset) m_ovf = 1'b0;
        end else begin
            m_valid = '0;
            for (int s = 0; s < CDB_WIDTH; s++) m_out[s] = '0;
            for (int j = 0; j < NUM_FU; j++) begin
                int f;
                f = (m_rr + j) % NUM_FU;
                if (k < CDB_WIDTH && mq[f].size() > 0) begin
                    m_out[k]   = mq[f].pop_front();
                    m_valid[k] = 1'b1;
                    k++;
                    last = f;
                end
            end
            if (k > 0) m_rr = (last + 1) % NUM_FU;
            for (int i = 0; i < NUM_FU; i++) begin
                if (want[i] && fu_in[i].valid) begin
                    if (mq[i].size() < QDEPTH) mq[i].push_back(fu_in[i]);
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [NUM_FU-1:0] es;
        for (int i = 0; i < NUM_FU; i++) es[i] = (mq[i].size() >= QDEPTH - STALL_MARGIN);
        check_bits("model cdb_valid", 64'(cdb_valid), 64'(m_valid));
        for (int s = 0; s < CDB_WIDTH; s++)
            check_bits($sformatf("model slot%0d packet", s), pk64(cdb_packet_out[s]), pk64(m_out[s]));
        check_bits("model complete_stall", 64'(complete_stall), 64'(es));
        check_bits("model overflow_err", 64'(overflow_err), 64'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic set_inputs(input logic r, input logic s, input logic [3:0] w, input bit drop_valid);
        reset  = r;
        squash = s;
        want   = w;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_in[i] = rand_pkt();
            if (drop_valid ? ($urandom_range(0, 7) == 0) : (!w[i] && $urandom_range(0, 1) == 0))
                fu_in[i].valid = 1'b0;
        end
    endtask

    function automatic void add(input logic r, input logic s, input logic [3:0] w,
                                input logic [1:0] ev, input logic [3:0] es, input logic eo);
        vec_t v;
        v.rst_n = r; v.sq = s; v.want = w; v.ev = ev; v.es = es; v.eo = eo;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        fu_complete_packet_t fu0_pkt;
        logic [3:0] w;

        m_rr = 0; m_ovf = 1'b0; m_valid = '0;
        for (int s = 0; s < CDB_WIDTH; s++) m_out[s] = '0;

        add(0, 0, 4'h0, 2'b00, 4'h0, 0);
        add(1, 0, 4'h2, 2'b00, 4'h0, 0);
        add(1, 0, 4'h0, 2'b01, 4'h0, 0);
        add(1, 0, 4'h0, 2'b00, 4'h0, 0);
        add(1, 1, 4'h0, 2'b00, 4'h0, 0);
        add(1, 0, 4'hF, 2'b00, 4'h0, 0);
        add(1, 0, 4'h0, 2'b11, 4'h0, 0);
        add(1, 0, 4'h0, 2'b11, 4'h0, 0);
        add(1, 0, 4'h0, 2'b00, 4'h0, 0);
        add(1, 0, 4'hF, 2'b00, 4'h0, 0);
        for (int n = 0; n < 4; n++) add(1, 0, 4'hF, 2'b11, 4'h0, 0);
        add(1, 0, 4'hF, 2'b11, 4'hC, 0);
        add(1, 0, 4'hF, 2'b11, 4'hF, 0);
        add(1, 0, 4'h0, 2'b11, 4'hC, 0);
        add(1, 0, 4'h0, 2'b11, 4'h0, 0);
        for (int n = 0; n < 6; n++) add(1, 0, 4'h0, 2'b11, 4'h0, 0);
        add(1, 0, 4'h0, 2'b00, 4'h0, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            set_inputs(tbl[r].rst_n, tbl[r].sq, tbl[r].want, 1'b0);
            tick();
            check_bits($sformatf("vec%0d cdb_valid", r), 64'(cdb_valid), 64'(tbl[r].ev));
            check_bits($sformatf("vec%0d complete_stall", r), 64'(complete_stall), 64'(tbl[r].es));
            check_bits($sformatf("vec%0d overflow_err", r), 64'(overflow_err), 64'(tbl[r].eo));
        end

        // Full FIFO0: push with grant keeps it, push without grant drops.
        for (int n = 0; n < 14; n++) begin
            set_inputs(1, 0, 4'hF, 1'b0);
            tick();
        end
        check_bits("fill overflow_err", 64'(overflow_err), 64'(0));
        set_inputs(1, 0, 4'h3, 1'b0);
        tick();
        set_inputs(1, 0, 4'h1, 1'b0);
        tick();
        check_bits("full+grant overflow_err", 64'(overflow_err), 64'(0));
        check_bits("full+grant cdb_valid", 64'(cdb_valid), 64'(2'b11));
        set_inputs(1, 0, 4'h1, 1'b0);
        tick();
        check_bits("full no-grant overflow_err", 64'(overflow_err), 64'(1));

        // Reset while loaded and overflowed, then a fresh push.
        set_inputs(0, 0, 4'hF, 1'b0);
        tick();
        check_bits("reset cdb_valid", 64'(cdb_valid), 64'(0));
        check_bits("reset complete_stall", 64'(complete_stall), 64'(0));
        check_bits("reset overflow_err", 64'(overflow_err), 64'(0));
        set_inputs(1, 0, 4'h4, 1'b0);
        tick();
        check_bits("post-reset push cdb_valid", 64'(cdb_valid), 64'(0));
        set_inputs(1, 0, 4'h0, 1'b0);
        tick();
        check_bits("post-reset emerge cdb_valid", 64'(cdb_valid), 64'(2'b01));

        // Squash with FU3 holding several packets.
        for (int n = 0; n < 4; n++) begin
            set_inputs(1, 0, 4'hF, 1'b0);
            tick();
        end
        set_inputs(1, 1, 4'hF, 1'b0);
        tick();
        check_bits("squash cdb_valid", 64'(cdb_valid), 64'(0));
        check_bits("squash complete_stall", 64'(complete_stall), 64'(0));
        set_inputs(1, 0, 4'hF, 1'b0);
        fu0_pkt = fu_in[0];
        tick();
        set_inputs(1, 0, 4'h0, 1'b0);
        tick();
        check_bits("squash rr restart slot0", pk64(cdb_packet_out[0]), pk64(fu0_pkt));
        check_bits("squash rr restart cdb_valid", 64'(cdb_valid), 64'(2'b11));

        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NUM_FU; i++)
                w[i] = ($urandom_range(0, 3) != 0) && (!complete_stall[i] || $urandom_range(0, 15) == 0);
            set_inputs($urandom_range(0, 299) != 0, $urandom_range(0, 49) == 0, w, 1'b1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
